// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if
//   Groups the two busses of the instruction memory loader:
//   - the incoming byte stream (valid/data from the source, ready back from the loader)
//   - the instruction RAM write port (we/address/data from the loader)
//   The loader uses the master modport. The byte source and RAM side use the slave modport.
//
//   byte_valid  source -> loader  byte_data is valid this cycle
//   byte_data   source -> loader  stream byte
//   byte_ready  loader -> source  loader accepts a byte this cycle
//   mem_we      loader -> RAM     write strobe, one cycle per word
//   mem_a       loader -> RAM     word-aligned byte address
//   mem_wd      loader -> RAM     write data
interface inst_mem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_a,
    output mem_wd
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_a,
    input  mem_wd
  );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Boot-time writer for the instruction RAM. After a start pulse it reads a
//   4-byte little-endian word count N, then N little-endian 32-bit words. The
//   words are written to consecutive word addresses from 0. The core is held
//   in reset until the image has been loaded completely.
//
//   Ports:
//     clk      clock, rising edge
//     rst      synchronous active-high reset
//     start    one-cycle pulse that arms a load (accepted in IDLE, DONE, ERR)
//     bus      byte stream in + RAM write port out (inst_mem_loader_if.master)
//     cpu_rst  core reset request, low only once DONE has settled
//     busy     loading header or data
//     done     image fully loaded (also for N == 0)
//     err      header asked for more words than the RAM holds
module inst_mem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inst_mem_loader_if.master bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [31:0] MAX_WORDS = 32'(MEM_SIZE / 4);

  logic [2:0]  state_q,    state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q,      asm_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic        mem_we_q,   mem_we_d;
  logic [31:0] mem_a_q,    mem_a_d;
  logic [31:0] mem_wd_q,   mem_wd_d;
  logic        cpu_rst_q,  cpu_rst_d;

  logic        accepting;
  logic        xfer;
  logic [31:0] full_word;

  assign accepting = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign xfer      = bus.byte_valid && accepting;
  // Only three bytes are ever buffered; the fourth comes straight off the bus.
  assign full_word = {bus.byte_data, asm_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    mem_we_d   = 1'b0;
    mem_a_d    = mem_a_q;
    mem_wd_d   = mem_wd_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN;
          byte_cnt_d = 2'd0;
          asm_d      = 24'd0;
          word_cnt_d = 32'd0;
          word_idx_d = 32'd0;
        end
      end

      ST_LEN, ST_DATA: begin
        if (xfer) begin
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = bus.byte_data;
            2'd1: asm_d[15:8]  = bus.byte_data;
            2'd2: asm_d[23:16] = bus.byte_data;
            default: asm_d     = 24'd0;
          endcase

          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            if (state_q == ST_LEN) begin
              word_cnt_d = full_word;
              if (full_word == 32'd0) begin
                state_d = ST_DONE;
              end else if (full_word > MAX_WORDS) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_DATA;
              end
            end else begin
              // word_idx_q < word_cnt_q <= MAX_WORDS, so the address stays inside the RAM.
              mem_we_d   = 1'b1;
              mem_a_d    = {word_idx_q[29:0], 2'b00};
              mem_wd_d   = full_word;
              word_idx_d = word_idx_q + 32'd1;
              if (word_idx_q == (word_cnt_q - 32'd1)) begin
                state_d = ST_DONE;
              end
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The core leaves reset only once DONE has held for a full cycle, so the
    // final write has reached the RAM; re-arming from DONE re-asserts it at once.
    cpu_rst_d = !((state_q == ST_DONE) && (state_d == ST_DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      word_cnt_q <= 32'd0;
      word_idx_q <= 32'd0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_wd_q   <= 32'd0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      word_idx_q <= word_idx_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign bus.byte_ready = accepting;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_wd     = mem_wd_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = accepting;
  assign done           = (state_q == ST_DONE);
  assign err            = (state_q == ST_ERR);

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader
//   Self-checking bench for inst_mem_loader. A reference model turns a byte
//   image into the list of RAM writes the loader must produce. A table of
//   header cases drives randomized images with random valid gaps. Hand-written
//   sequences cover cycle timing, reset mid-load, and start during DATA.
module tb_inst_mem_loader;
  localparam int MEM_SIZE = 1024;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst;
  logic busy;
  logic done;
  logic err;

  inst_mem_loader_if ifc ();

  inst_mem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (ifc),
    .cpu_rst(cpu_rst),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] n;
    logic [7:0]  gap_max;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_words;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] img_q[$];
  logic [63:0] cap_q[$];
  logic [63:0] exp_q[$];
  bit         exp_done;
  bit         exp_err;

  // Every cycle with the write strobe high is one RAM write.
  always @(negedge clk) begin
    if (ifc.mem_we) cap_q.push_back({ifc.mem_a, ifc.mem_wd});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: the image is a count N followed by N words, stored at 4*w.
  function automatic void build_expected(input logic [7:0] s[$]);
    logic [31:0] n;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = {s[3], s[2], s[1], s[0]};
    if (n == 32'd0) begin
      exp_done = 1'b1;
    end else if (n > 32'(MEM_SIZE / 4)) begin
      exp_err = 1'b1;
    end else begin
      exp_done = 1'b1;
      for (int w = 0; w < int'(n); w++)
        exp_q.push_back({32'(w * 4), s[4*w+7], s[4*w+6], s[4*w+5], s[4*w+4]});
    end
  endfunction

  // Header plus random payload (payload only if the count fits in the RAM).
  function automatic void make_image(input logic [31:0] n);
    img_q.delete();
    img_q.push_back(n[7:0]);
    img_q.push_back(n[15:8]);
    img_q.push_back(n[23:16]);
    img_q.push_back(n[31:24]);
    if (n <= 32'(MEM_SIZE / 4))
      for (int i = 0; i < int'(n) * 4; i++) img_q.push_back(8'($urandom_range(0, 255)));
  endfunction

  function automatic void compare_writes(input string tag);
    int n;
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL %s_write_count: got %0d required %0d", tag, cap_q.size(), exp_q.size());
    end
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL %s_write%0d: got A=0x%08h WD=0x%08h required A=0x%08h WD=0x%08h",
                 tag, i, cap_q[i][63:32], cap_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
      end
    end
  endfunction

  // Starts a load from a negedge; returns at the negedge of the first LEN cycle.
  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_len_busy"}, busy, 1);
    checkOutput({tag, "_len_ready"}, ifc.byte_ready, 1);
    checkOutput({tag, "_len_cpu_rst"}, cpu_rst, 1);
  endtask

  // Sends the bytes with up to gap_max idle cycles before each one. start is
  // raised together with byte start_at. Returns at the negedge right after the
  // edge that accepted the last byte.
  task automatic applyStimulus(input logic [7:0] s[$], input int gap_max, input int start_at,
                               output int stalls);
    int  gaps;
    int  waited;
    bit  accepted;
    bit  rdy;
    stalls = 0;
    for (int i = 0; i < s.size(); i++) begin
      gaps = $urandom_range(0, gap_max);
      ifc.byte_valid = 1'b0;
      for (int g = 0; g < gaps; g++) @(negedge clk);
      ifc.byte_valid = 1'b1;
      ifc.byte_data  = s[i];
      start          = (i == start_at);
      accepted = 1'b0;
      waited   = 0;
      while (!accepted && waited < 20) begin
        rdy = ifc.byte_ready;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (rdy) accepted = 1'b1;
        else begin
          stalls++;
          waited++;
        end
      end
      if (!accepted) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout: byte %0d not taken in 20 cycles, required acceptance", i);
        break;
      end
    end
    ifc.byte_valid = 1'b0;
  endtask

  vec_t       vecs[9];
  logic [7:0] part_q[$];
  int         stalls;
  int         seen;

  initial begin
    vecs[0] = '{n: 32'd2,          gap_max: 8'd0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2};
    vecs[1] = '{n: 32'd0,          gap_max: 8'd3, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd0};
    vecs[2] = '{n: 32'd5,          gap_max: 8'd5, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd5};
    vecs[3] = '{n: 32'd256,        gap_max: 8'd0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd256};
    vecs[4] = '{n: 32'd257,        gap_max: 8'd2, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};
    vecs[5] = '{n: 32'd1,          gap_max: 8'd5, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd1};
    vecs[6] = '{n: 32'h8000_0001,  gap_max: 8'd0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};
    vecs[7] = '{n: 32'hFFFF_FFFF,  gap_max: 8'd1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};
    vecs[8] = '{n: 32'h0001_0000,  gap_max: 8'd0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};

    rst = 1'b1;
    start = 1'b0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cpu_rst", cpu_rst, 1);
    checkOutput("rst_ready", ifc.byte_ready, 0);
    checkOutput("rst_mem_we", ifc.mem_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_mem_a", ifc.mem_a, 0);
    checkOutput("rst_mem_wd", ifc.mem_wd, 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back image: exact write timing and cpu_rst release.
    $display("[TB] sequence: two-word image, no gaps");
    img_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    build_expected(img_q);
    cap_q.delete();
    pulse_start("t1");
    applyStimulus(img_q, 0, -1, stalls);
    checkOutput("t1_stalls", stalls, 0);
    checkOutput("t1_last_we", ifc.mem_we, 1);
    checkOutput("t1_last_a", ifc.mem_a, 32'h4);
    checkOutput("t1_last_wd", ifc.mem_wd, 32'h0020_0593);
    checkOutput("t1_done_early", done, 1);
    checkOutput("t1_busy_low", busy, 0);
    checkOutput("t1_ready_low", ifc.byte_ready, 0);
    checkOutput("t1_cpu_rst_held", cpu_rst, 1);
    @(negedge clk);
    checkOutput("t1_we_drop", ifc.mem_we, 0);
    checkOutput("t1_cpu_rst_fall", cpu_rst, 0);
    compare_writes("t1");
    if (cap_q.size() > 0) checkOutput("t1_first_wd", cap_q[0][31:0], 32'h0010_0513);

    $display("[TB] sequence: same image with random gaps");
    cap_q.delete();
    pulse_start("t2");
    applyStimulus(img_q, 5, -1, stalls);
    checkOutput("t2_done", done, 1);
    @(negedge clk);
    compare_writes("t2");

    $display("[TB] table of header cases");
    for (int v = 0; v < 9; v++) begin
      make_image(vecs[v].n);
      build_expected(img_q);
      cap_q.delete();
      pulse_start($sformatf("v%0d", v));
      applyStimulus(img_q, int'(vecs[v].gap_max), -1, stalls);
      checkOutput($sformatf("v%0d_stalls", v), stalls, 0);
      checkOutput($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      checkOutput($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      checkOutput($sformatf("v%0d_busy", v), busy, 0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_cpu_rst", v), cpu_rst, !vecs[v].exp_done);
      checkOutput($sformatf("v%0d_words", v), cap_q.size(), vecs[v].exp_words);
      compare_writes($sformatf("v%0d", v));
      if (vecs[v].exp_err) begin
        seen = 0;
        ifc.byte_valid = 1'b1;
        repeat (6) begin
          if (ifc.byte_ready) seen++;
          @(negedge clk);
        end
        ifc.byte_valid = 1'b0;
        checkOutput($sformatf("v%0d_err_no_accept", v), seen, 0);
        checkOutput($sformatf("v%0d_err_hold", v), err, 1);
        checkOutput($sformatf("v%0d_err_no_write", v), cap_q.size(), 0);
      end
    end

    // Reset after 6 DATA bytes; start in the same cycle must lose to reset.
    $display("[TB] sequence: reset mid-load");
    make_image(32'd4);
    build_expected(img_q);
    part_q.delete();
    for (int i = 0; i < 10; i++) part_q.push_back(img_q[i]);
    cap_q.delete();
    pulse_start("t5");
    applyStimulus(part_q, 1, -1, stalls);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_ready", ifc.byte_ready, 0);
    checkOutput("t5_mem_we", ifc.mem_we, 0);
    checkOutput("t5_cpu_rst", cpu_rst, 1);
    checkOutput("t5_mem_a", ifc.mem_a, 0);
    checkOutput("t5_mem_wd", ifc.mem_wd, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t5_partial_words", cap_q.size(), 1);
    if (cap_q.size() > 0) checkOutput("t5_word0_wd", cap_q[0][31:0], exp_q[0][31:0]);
    make_image(32'd1);
    build_expected(img_q);
    cap_q.delete();
    pulse_start("t5b");
    applyStimulus(img_q, 2, -1, stalls);
    @(negedge clk);
    compare_writes("t5b");

    $display("[TB] sequence: start during DATA");
    make_image(32'd3);
    build_expected(img_q);
    cap_q.delete();
    pulse_start("t6");
    applyStimulus(img_q, 2, 9, stalls);
    checkOutput("t6_done", done, 1);
    @(negedge clk);
    compare_writes("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
